spike_event_logger: RTL and testbench

Downstream consumer of the `lif` neuron's `spike` and `state` outputs. Detects each spike onset, stamps it with a free-running cycle timestamp, and captures the membrane state at the crossing. Buffers events in a small FIFO and streams each record off-chip as two bytes over a valid/ready byte interface. Gives the bench and the silicon a lossless-or-flagged log of neuron activity.

---
 rtl/spike_pkg.sv | 27 ++
 rtl/spike_event_logger_if.sv | 12 +
 rtl/spike_fifo.sv | 58 +++++
 rtl/spike_event_logger.sv | 122 ++++++++++++
 tb/tb_spike_event_logger.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/spike_pkg.sv
// Shared definitions for the spike event logger: record layout, output FSM
// encoding and default buffer depth.
package spike_pkg;

   localparam int SPIKE_REC_W   = 16;
   localparam int BYTE_W        = 8;
   localparam int REC_TS_MSB    = 15;
   localparam int REC_TS_LSB    = 8;
   localparam int REC_STATE_MSB = 7;
   localparam int REC_STATE_LSB = 0;
   localparam int DEFAULT_DEPTH = 8;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SEND_TS    = 2'd1,
      SEND_STATE = 2'd2
   } out_state_t;

   function automatic logic [BYTE_W-1:0] rec_ts(input logic [SPIKE_REC_W-1:0] rec);
      return rec[REC_TS_MSB:REC_TS_LSB];
   endfunction

   function automatic logic [BYTE_W-1:0] rec_state(input logic [SPIKE_REC_W-1:0] rec);
      return rec[REC_STATE_MSB:REC_STATE_LSB];
   endfunction

endpackage

// File: rtl/spike_event_logger_if.sv
// Byte-wide valid/ready stream carrying serialized spike records off-chip.
interface spike_event_logger_if;
   import spike_pkg::*;

   logic [BYTE_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/spike_fifo.sv
// Small synchronous FIFO with registered count. Read side is combinational so
// the head can be loaded into the consumer's holding register in the pop cycle.
module spike_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign full     = (count_reg == CNT_FULL);
   assign empty    = (count_reg == '0);
   assign count    = count_reg;
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_ONE;
            2'b01:   count_reg <= count_reg - CNT_ONE;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/spike_event_logger.sv
// Logs spike onsets as {timestamp, membrane state} records, buffers them and
// streams each record as two bytes; drops on a full buffer are flagged and counted.
module spike_event_logger
   import spike_pkg::*;
#(
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int TS_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    spike_in,
   input  logic [7:0]              state_in,
   input  logic                    clear_overflow,
   spike_event_logger_if.master    out_if,
   output logic [$clog2(DEPTH):0]  fifo_count,
   output logic                    overflow,
   output logic [7:0]              drop_count
);

   logic [TS_WIDTH-1:0]    ts_reg;
   logic                   prev_spike_reg;
   logic                   overflow_reg;
   logic [7:0]             drop_count_reg;
   out_state_t             state_reg, state_next;
   logic [SPIKE_REC_W-1:0] hold_reg, hold_next;
   logic [BYTE_W-1:0]      out_data_reg, out_data_next;
   logic                   out_valid_reg, out_valid_next;

   logic                   onset, fifo_full, fifo_empty, push, drop, pop;
   logic [SPIKE_REC_W-1:0] record, rd_data;

   assign onset  = spike_in && !prev_spike_reg;
   assign push   = onset && !fifo_full;
   assign drop   = onset && fifo_full;
   assign record = {ts_reg, state_in};

   spike_fifo #(.WIDTH(SPIKE_REC_W), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (record),
      .pop       (pop),
      .pop_data  (rd_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // prev_spike resets high so a spike already asserted at release is ignored.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ts_reg         <= '0;
         prev_spike_reg <= 1'b1;
         overflow_reg   <= 1'b0;
         drop_count_reg <= '0;
      end else begin
         ts_reg         <= ts_reg + TS_WIDTH'(1);
         prev_spike_reg <= spike_in;
         if (drop) begin
            overflow_reg   <= 1'b1;
            if (clear_overflow)            drop_count_reg <= 8'd1;
            else if (drop_count_reg != 8'hFF) drop_count_reg <= drop_count_reg + 8'd1;
         end else if (clear_overflow) begin
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         hold_reg      <= '0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         hold_reg      <= hold_next;
         out_data_reg  <= out_data_next;
         out_valid_reg <= out_valid_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      hold_next      = hold_reg;
      out_data_next  = out_data_reg;
      out_valid_next = out_valid_reg;
      pop            = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               pop            = 1'b1;
               hold_next      = rd_data;
               out_data_next  = rec_ts(rd_data);
               out_valid_next = 1'b1;
               state_next     = SEND_TS;
            end
         end
         SEND_TS: begin
            out_data_next = out_if.out_ready ? rec_state(hold_reg) : rec_ts(hold_reg);
            if (out_if.out_ready) state_next = SEND_STATE;
         end
         SEND_STATE: begin
            if (out_if.out_ready) begin
               out_valid_next = 1'b0;
               state_next     = IDLE;
            end
         end
         default: begin
            out_valid_next = 1'b0;
            state_next     = IDLE;
         end
      endcase
   end

   assign out_if.out_data  = out_data_reg;
   assign out_if.out_valid = out_valid_reg;
   assign overflow         = overflow_reg;
   assign drop_count       = drop_count_reg;

endmodule

// File: tb/tb_spike_event_logger.sv
// Directed bench for spike_event_logger: latency, back-pressure, overflow,
// reset-held spikes, timestamp wrap and reset during transmission.
module tb_spike_event_logger;
   import spike_pkg::*;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       spike_in = 1'b0;
   logic [7:0] state_in = 8'h00;
   logic       clear_overflow = 1'b0;
   logic [3:0] fifo_count;
   logic       overflow;
   logic [7:0] drop_count;

   spike_event_logger_if bus();

   spike_event_logger #(.DEPTH(DEPTH), .TS_WIDTH(8)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .spike_in       (spike_in),
      .state_in       (state_in),
      .clear_overflow (clear_overflow),
      .out_if         (bus),
      .fifo_count     (fifo_count),
      .overflow       (overflow),
      .drop_count     (drop_count)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_pass = 0;
   int         cyc = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   // Bytes accepted at the coming rising edge.
   always @(negedge clk) begin
      #1;
      if (reset_n && bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      cyc = 0;
   endtask

   task automatic pulse(input logic [7:0] s, input bit keep);
      logic [31:0] c;
      c = cyc;
      spike_in = 1'b1;
      state_in = s;
      if (keep) begin
         exp_q.push_back(c[7:0]);
         exp_q.push_back(s);
      end
      tick();
      spike_in = 1'b0;
      tick();
   endtask

   task automatic wait_bytes(input string tag);
      int n;
      logic [31:0] g;
      n = exp_q.size();
      for (int i = 0; i < 200 && got_q.size() < n; i++) tick();
      check_val({tag, "_nbytes"}, got_q.size(), n);
      for (int i = 0; i < n; i++) begin
         g = (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hDEAD;
         check_val($sformatf("%s_byte%0d", tag, i), g, {24'h0, exp_q[i]});
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.out_ready = 1'b1;
      #1 reset_n = 1'b0;
      @(negedge clk);
      check_val("rst_valid", bus.out_valid, 1'b0);
      check_val("rst_data", bus.out_data, 8'h00);
      check_val("rst_count", fifo_count, 4'd0);
      check_val("rst_overflow", overflow, 1'b0);
      check_val("rst_drops", drop_count, 8'd0);
      tick();
      reset_n = 1'b1;
      cyc = 0;

      // Single onset at ts=10 held for five cycles.
      repeat (10) tick();
      spike_in = 1'b1;
      state_in = 8'h37;
      exp_q.push_back(8'h0A);
      exp_q.push_back(8'h37);
      tick();
      check_val("t1_count_n1", fifo_count, 4'd1);
      check_val("t1_valid_n1", bus.out_valid, 1'b0);
      tick();
      check_val("t1_valid_n2", bus.out_valid, 1'b1);
      check_val("t1_data_n2", bus.out_data, 8'h0A);
      tick();
      check_val("t1_valid_n3", bus.out_valid, 1'b1);
      check_val("t1_data_n3", bus.out_data, 8'h37);
      tick();
      check_val("t1_valid_n4", bus.out_valid, 1'b0);
      tick();
      spike_in = 1'b0;
      wait_bytes("t1");
      repeat (4) tick();
      check_val("t1_single_record", got_q.size(), 0);

      // Back-pressure with three queued onsets.
      bus.out_ready = 1'b0;
      pulse(8'h40, 1'b1);
      pulse(8'h41, 1'b1);
      pulse(8'h42, 1'b1);
      check_val("t2_count", fifo_count, 4'd2);
      check_val("t2_valid", bus.out_valid, 1'b1);
      check_val("t2_hold_ts", bus.out_data, exp_q[0]);
      repeat (3) tick();
      check_val("t2_stable_ts", bus.out_data, exp_q[0]);
      check_val("t2_stable_valid", bus.out_valid, 1'b1);
      bus.out_ready = 1'b1;
      wait_bytes("t2");

      // Overflow: eleven onsets, nine kept.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 11; i++) pulse(8'h60 + 8'(i), i < 9);
      check_val("t3_count_full", fifo_count, 4'd8);
      check_val("t3_overflow", overflow, 1'b1);
      check_val("t3_drops", drop_count, 8'd2);
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      check_val("t3_clr_overflow", overflow, 1'b0);
      check_val("t3_clr_drops", drop_count, 8'd0);
      spike_in = 1'b1;
      clear_overflow = 1'b1;
      tick();
      spike_in = 1'b0;
      clear_overflow = 1'b0;
      check_val("t3_drop_wins_ovf", overflow, 1'b1);
      check_val("t3_drop_wins_cnt", drop_count, 8'd1);
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      check_val("t3_reclear_cnt", drop_count, 8'd0);
      bus.out_ready = 1'b1;
      wait_bytes("t3");
      check_val("t3_drained", fifo_count, 4'd0);

      // Spike held through reset release is not logged.
      spike_in = 1'b1;
      do_reset();
      repeat (5) tick();
      check_val("t4_no_count", fifo_count, 4'd0);
      check_val("t4_no_valid", bus.out_valid, 1'b0);
      spike_in = 1'b0;
      tick();
      pulse(8'h55, 1'b1);
      wait_bytes("t4");
      repeat (5) tick();
      check_val("t4_single_record", got_q.size(), 0);

      // Timestamp at the wrap boundary.
      do_reset();
      repeat (255) tick();
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h77);
      pulse(8'h77, 1'b0);
      wait_bytes("t5_ts255");
      do_reset();
      repeat (256) tick();
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h78);
      pulse(8'h78, 1'b0);
      wait_bytes("t5_ts256");

      // Reset asserted while the state byte is on the bus.
      do_reset();
      bus.out_ready = 1'b1;
      repeat (3) tick();
      spike_in = 1'b1;
      state_in = 8'h21;
      exp_q.push_back(8'h03);
      tick();
      spike_in = 1'b0;
      tick();
      spike_in = 1'b1;
      state_in = 8'h22;
      tick();
      spike_in = 1'b0;
      bus.out_ready = 1'b0;
      check_val("t6_pre_valid", bus.out_valid, 1'b1);
      check_val("t6_pre_data", bus.out_data, 8'h21);
      check_val("t6_pre_count", fifo_count, 4'd1);
      #1 reset_n = 1'b0;
      #1;
      check_val("t6_async_valid", bus.out_valid, 1'b0);
      check_val("t6_async_count", fifo_count, 4'd0);
      check_val("t6_async_data", bus.out_data, 8'h00);
      @(negedge clk);
      tick();
      reset_n = 1'b1;
      cyc = 0;
      bus.out_ready = 1'b1;
      repeat (10) tick();
      wait_bytes("t6");
      check_val("t6_idle_after", bus.out_valid, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
